apb_serial_router: RTL and testbench

- Parametrised, APB-configurable serial packet router.
- Receives framed serial packets on data_in/valid_in and decodes a destination header.
- Forwards the payload serially on one of NUM_PORTS output ports.
- APB register bank provides enable/port-mask control, status, drop counting and per-port packet counters for register-layer verification.

---
 rtl/apb_serial_router.sv | 199 +++++++++++++++++++
 tb/tb_apb_serial_router.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_serial_router.sv
// Serial packet router: decodes a destination header from a framed bit stream and
// forwards the payload on one of NUM_PORTS outputs; APB bank for control, status and counters.
module apb_serial_router #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned DEST_W       = 2,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 presetn,
  input  logic [31:0]          paddr,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [31:0]          pwdata,
  output logic [31:0]          prdata,
  output logic                 pready,
  output logic                 pslverr,
  input  logic                 data_in,
  input  logic                 valid_in,
  output logic [NUM_PORTS-1:0] data_out,
  output logic [NUM_PORTS-1:0] valid_out
);

  localparam int unsigned FRAME_LEN = DEST_W + PAYLOAD_BITS;
  localparam int unsigned BCNT_W    = $clog2(FRAME_LEN + 1);
  localparam int unsigned DEST_N    = 1 << DEST_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RX   = 2'd1,
    S_FWD  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    armed_q;
  logic                    en_q;
  logic [NUM_PORTS-1:0]    port_en_q;
  logic [FRAME_LEN-2:0]    shift_q, shift_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic [DEST_W-1:0]       dest_q, dest_d;
  logic [PAYLOAD_BITS-1:0] pay_q, pay_d;
  logic [CNT_W-1:0]        drop_q;
  logic [CNT_W-1:0]        pkt_q [NUM_PORTS];

  logic [FRAME_LEN-1:0]    frame_full;
  logic [DEST_W-1:0]       dest_full;
  logic [DEST_N-1:0]       port_en_ext;
  logic                    drop_inc;
  logic [NUM_PORTS-1:0]    pkt_inc;

  logic                    apb_acc, apb_wr, apb_rd;
  logic [7:0]              addr;
  logic                    mapped;
  logic [31:0]             rdata;
  logic                    ctrl_wr, drop_clr;
  logic [NUM_PORTS-1:0]    pkt_clr;
  logic [1:0]              state_bits;
  logic                    unused_bits;

  assign frame_full  = {shift_q, data_in};
  assign dest_full   = frame_full[FRAME_LEN-1 -: DEST_W];
  // Zero-extended so destinations beyond NUM_PORTS decode as disabled.
  assign port_en_ext = DEST_N'(port_en_q);
  assign state_bits  = state_q;
  assign unused_bits = ^{paddr[31:8], pwdata[31:8+NUM_PORTS], pwdata[7:1]};

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcnt_d   = bcnt_q;
    dest_d   = dest_q;
    pay_d    = pay_q;
    drop_inc = 1'b0;
    pkt_inc  = '0;
    case (state_q)
      S_IDLE: begin
        if (armed_q && valid_in && en_q) begin
          state_d = S_RX;
          shift_d = (FRAME_LEN-1)'(data_in);
          bcnt_d  = BCNT_W'(1);
        end
      end
      S_RX: begin
        if (!valid_in) begin
          state_d  = S_IDLE;
          drop_inc = 1'b1;
        end else begin
          shift_d = frame_full[FRAME_LEN-2:0];
          bcnt_d  = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(FRAME_LEN - 1)) begin
            dest_d = dest_full;
            pay_d  = frame_full[PAYLOAD_BITS-1:0];
            bcnt_d = '0;
            if (port_en_ext[dest_full]) begin
              state_d = S_FWD;
            end else begin
              state_d  = S_IDLE;
              drop_inc = 1'b1;
            end
          end
        end
      end
      S_FWD: begin
        pay_d  = pay_q << 1;
        bcnt_d = bcnt_q + BCNT_W'(1);
        if (bcnt_q == BCNT_W'(PAYLOAD_BITS - 1)) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
          pkt_inc = NUM_PORTS'(1) << dest_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign valid_out = (state_q == S_FWD) ? (NUM_PORTS'(1) << dest_q) : '0;
  assign data_out  = valid_out & {NUM_PORTS{pay_q[PAYLOAD_BITS-1]}};

  assign apb_acc = psel & penable;
  assign apb_wr  = apb_acc & pwrite;
  assign apb_rd  = apb_acc & ~pwrite;
  assign addr    = paddr[7:0];

  always_comb begin
    mapped   = 1'b0;
    rdata    = '0;
    ctrl_wr  = 1'b0;
    drop_clr = 1'b0;
    pkt_clr  = '0;
    case (addr)
      8'h00: begin
        mapped  = 1'b1;
        rdata   = 32'(en_q) | (32'(port_en_q) << 8);
        ctrl_wr = apb_wr;
      end
      8'h04: begin
        mapped = 1'b1;
        rdata  = {16'h0000, 8'(dest_q), 6'b000000, state_bits};
      end
      8'h08: begin
        mapped   = 1'b1;
        rdata    = 32'(drop_q);
        drop_clr = apb_wr;
      end
      default: begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (addr == 8'(16 + 4 * i)) begin
            mapped     = 1'b1;
            rdata      = 32'(pkt_q[i]);
            pkt_clr[i] = apb_wr;
          end
        end
      end
    endcase
  end

  assign prdata  = (apb_rd && mapped) ? rdata : '0;
  assign pslverr = apb_acc & ~mapped;
  assign pready  = 1'b1;

  // A clear landing together with an increment leaves the count at 1.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic clr, input logic inc);
    if (clr)                 return inc ? CNT_W'(1) : '0;
    else if (inc && c != '1) return c + CNT_W'(1);
    else                     return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      en_q      <= 1'b0;
      port_en_q <= '1;
      shift_q   <= '0;
      bcnt_q    <= '0;
      dest_q    <= '0;
      pay_q     <= '0;
      drop_q    <= '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) pkt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= (state_q == S_IDLE) && !valid_in;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      dest_q  <= dest_d;
      pay_q   <= pay_d;
      if (ctrl_wr) begin
        en_q      <= pwdata[0];
        port_en_q <= pwdata[8 +: NUM_PORTS];
      end
      drop_q <= cnt_next(drop_q, drop_clr, drop_inc);
      for (int unsigned i = 0; i < NUM_PORTS; i++)
        pkt_q[i] <= cnt_next(pkt_q[i], pkt_clr[i], pkt_inc[i]);
    end
  end

endmodule

// File: tb/tb_apb_serial_router.sv
// Directed bench for apb_serial_router: frame forwarding, drops, APB access and counters.
module tb_apb_serial_router;

  localparam int unsigned CNT_W = 3;

  logic        clk = 1'b0;
  logic        presetn = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        data_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [3:0]  data_out;
  logic [3:0]  valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  apb_serial_router #(
    .NUM_PORTS(4),
    .DEST_W(2),
    .PAYLOAD_BITS(8),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .presetn(presetn),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    #1;
    d = prdata;
    err = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(a, d, e);
    check(tag, d, exp);
  endtask

  // Two idle cycles guarantee the router sees valid_in low while idle.
  task automatic send_frame(input logic [1:0] dest, input logic [7:0] pay, input int nbits);
    logic [9:0] f;
    f = {dest, pay};
    valid_in = 1'b0;
    tick();
    tick();
    for (int i = 0; i < nbits; i++) begin
      valid_in = 1'b1;
      data_in  = f[9-i];
      tick();
    end
    valid_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic expect_fwd(input int port, input logic [7:0] pay);
    logic [3:0] ev, ed;
    for (int c = 0; c < 8; c++) begin
      ev = 4'b0001 << port;
      ed = pay[7-c] ? ev : 4'b0000;
      check($sformatf("fwd_p%0d_b%0d", port, c), {24'h0, valid_out, data_out}, {24'h0, ev, ed});
      tick();
    end
    check("fwd_end", {28'h0, valid_out}, 32'h0);
  endtask

  task automatic expect_quiet(input int n);
    logic [3:0] acc;
    acc = '0;
    for (int c = 0; c < n; c++) begin
      acc |= valid_out | data_out;
      tick();
    end
    check("quiet", {28'h0, acc}, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;

    tick();
    tick();
    check("rst_valid_out", {28'h0, valid_out}, 32'h0);
    presetn = 1'b1;
    tick();
    check_reg("rst_ctrl", 32'h00, 32'h0000_0F00);
    check_reg("rst_status", 32'h04, 32'h0);
    check_reg("rst_drop", 32'h08, 32'h0);
    check_reg("rst_pkt0", 32'h10, 32'h0);

    apb_write(32'h00, 32'h0000_0F01);
    check_reg("ctrl_en", 32'h00, 32'h0000_0F01);
    send_frame(2'd2, 8'hA5, 10);
    expect_fwd(2, 8'hA5);
    check_reg("pkt2", 32'h18, 32'h1);
    check_reg("status_dest2", 32'h04, 32'h0000_0200);

    apb_write(32'h00, 32'h0000_0D01);
    send_frame(2'd1, 8'h3C, 10);
    expect_quiet(10);
    check_reg("drop_disabled", 32'h08, 32'h1);
    check_reg("pkt1_none", 32'h14, 32'h0);

    send_frame(2'd2, 8'h77, 5);
    expect_quiet(12);
    check_reg("drop_trunc", 32'h08, 32'h2);
    check_reg("pkt2_trunc", 32'h18, 32'h1);

    apb_write(32'h00, 32'h0000_0F01);
    fork
      send_frame(2'd3, 8'hFF, 10);
      begin
        repeat (5) tick();
        apb_write(32'h00, 32'h0000_0F00);
      end
    join
    expect_fwd(3, 8'hFF);
    send_frame(2'd0, 8'h11, 10);
    expect_quiet(10);
    check_reg("pkt3_en_off", 32'h1C, 32'h1);
    check_reg("pkt0_en_off", 32'h10, 32'h0);
    check_reg("drop_en_off", 32'h08, 32'h2);

    apb_read(32'h40, d, e);
    check("unmapped_err", {31'h0, e}, 32'h1);
    check("unmapped_data", d, 32'h0);
    apb_write(32'h40, 32'hFFFF_FFFF);
    apb_write(32'h04, 32'hFFFF_FFFF);
    check_reg("ro_ignored", 32'h00, 32'h0000_0F00);
    apb_read(32'h00, d, e);
    check("mapped_no_err", {31'h0, e}, 32'h0);

    apb_write(32'h00, 32'h0000_0F01);
    send_frame(2'd0, 8'h33, 10);
    expect_fwd(0, 8'h33);
    check_reg("pkt0_pre", 32'h10, 32'h1);
    send_frame(2'd0, 8'h5A, 10);
    fork
      expect_fwd(0, 8'h5A);
      begin
        repeat (6) tick();
        apb_write(32'h10, 32'h0);
      end
    join
    check_reg("pkt0_clr_inc", 32'h10, 32'h1);
    apb_write(32'h18, 32'h0);
    check_reg("pkt2_clr", 32'h18, 32'h0);

    apb_write(32'h08, 32'h0);
    check_reg("drop_clr", 32'h08, 32'h0);
    for (int k = 0; k < 9; k++) send_frame(2'd1, 8'h00, 1);
    expect_quiet(3);
    check_reg("drop_sat", 32'h08, 32'h7);

    send_frame(2'd1, 8'h81, 10);
    tick();
    tick();
    check("midfwd_active", {28'h0, valid_out}, 32'h2);
    presetn = 1'b0;
    tick();
    check("midfwd_rst_valid", {28'h0, valid_out}, 32'h0);
    presetn = 1'b1;
    tick();
    check_reg("midfwd_pkt1", 32'h14, 32'h0);
    check_reg("midfwd_pkt0", 32'h10, 32'h0);
    check_reg("midfwd_drop", 32'h08, 32'h0);
    check_reg("midfwd_ctrl", 32'h00, 32'h0000_0F00);
    check_reg("midfwd_status", 32'h04, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
